mac_sequencer: RTL

- Controller that runs one multiply-accumulate job: a series of dot products on an external signed MAC datapath.
- For each dot product it:
  - issues read addresses for the activation and weight operand RAMs (1-cycle read latency);
  - drives MAC enable/clear aligned with the returned data;
  - captures the accumulator result and presents it on a valid/ready handshake.
- Term count is set by layer: conv layers 0/1 have 25 terms, FC layer 2 has 192 terms.
- Sits between the layer-level network controller and the operand RAMs plus the MAC.

---
 rtl/mac_pkg.sv | 27 ++
 rtl/mac_addr_gen.sv | 60 ++++++
 rtl/mac_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// mac_pkg : shared layer/state encodings and term counts        rev 1.0
// ============================================================================
package mac_pkg;

  localparam int CONV_TERMS = 25;
  localparam int FC_TERMS   = 192;

  typedef enum logic [2:0] {
    LAYER_CONV1 = 3'd0,
    LAYER_CONV2 = 3'd1,
    LAYER_FC    = 3'd2
  } layer_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_ISSUE   = 3'd2,
    S_DRAIN   = 3'd3,
    S_SETTLE  = 3'd4,
    S_CAPTURE = 3'd5,
    S_HOLD    = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mac_addr_gen.sv
`default_nettype none
// ============================================================================
// mac_addr_gen : running per-output bases plus term counter     rev 1.0
// ============================================================================
module mac_addr_gen #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              advance,
  input  logic              clr,
  input  logic              step,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] stride_a,
  input  logic [ADDR_W-1:0] stride_b,
  input  logic [ADDR_W-1:0] n_terms,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              last
);

  logic [ADDR_W-1:0] r_run_a;
  logic [ADDR_W-1:0] r_run_b;
  logic [ADDR_W-1:0] r_stride_a;
  logic [ADDR_W-1:0] r_stride_b;
  logic [ADDR_W-1:0] r_i;

  // Stepping the base by stride per output replaces a k*stride multiply.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run_a    <= '0;
      r_run_b    <= '0;
      r_stride_a <= '0;
      r_stride_b <= '0;
      r_i        <= '0;
    end else begin
      if (load) begin
        r_run_a    <= base_a;
        r_run_b    <= base_b;
        r_stride_a <= stride_a;
        r_stride_b <= stride_b;
      end else if (advance) begin
        r_run_a <= r_run_a + r_stride_a;
        r_run_b <= r_run_b + r_stride_b;
      end
      if (clr)
        r_i <= '0;
      else if (step)
        r_i <= r_i + 1'b1;
    end
  end

  assign addr_a = r_run_a + r_i;
  assign addr_b = r_run_b + r_i;
  assign last   = (r_i == n_terms - 1'b1);

endmodule
`default_nettype wire

// File: rtl/mac_sequencer.sv
`default_nettype none
// ============================================================================
// mac_sequencer : dot-product job controller for an external MAC  rev 1.0
// ============================================================================
import mac_pkg::*;

module mac_sequencer #(
  parameter int ADDR_W     = 16,
  parameter int ACC_W      = 32,
  parameter int CONV_TERMS = mac_pkg::CONV_TERMS,
  parameter int FC_TERMS   = mac_pkg::FC_TERMS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        layer,
  input  logic [7:0]        num_outputs,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] stride_a,
  input  logic [ADDR_W-1:0] stride_b,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              rd_en,
  output logic              mac_clr,
  output logic              mac_en,
  input  logic [ACC_W-1:0]  acc_in,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            r_state;
  state_e            w_next;
  logic [7:0]        r_k;
  logic [7:0]        r_num;
  logic              r_fc;
  logic              w_load;
  logic              w_adv;
  logic              w_clr;
  logic              w_step;
  logic              w_done;
  logic              w_err;
  logic              w_last;
  logic              w_more;
  logic              w_layer_ok;
  logic [ADDR_W-1:0] w_n_terms;

  assign w_layer_ok = (layer == LAYER_CONV1) || (layer == LAYER_CONV2) || (layer == LAYER_FC);
  assign w_n_terms  = r_fc ? ADDR_W'(FC_TERMS) : ADDR_W'(CONV_TERMS);
  assign w_more     = (r_k + 8'd1) != r_num;
  assign busy       = (r_state != S_IDLE);

  mac_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (w_load),
    .advance  (w_adv),
    .clr      (w_clr),
    .step     (w_step),
    .base_a   (base_a),
    .base_b   (base_b),
    .stride_a (stride_a),
    .stride_b (stride_b),
    .n_terms  (w_n_terms),
    .addr_a   (addr_a),
    .addr_b   (addr_b),
    .last     (w_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    rd_en   = 1'b0;
    mac_clr = 1'b0;
    w_load  = 1'b0;
    w_adv   = 1'b0;
    w_clr   = 1'b0;
    w_step  = 1'b0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    if (abort && r_state != S_IDLE) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            if (!w_layer_ok)
              w_err = 1'b1;
            else if (num_outputs == 8'd0)
              w_done = 1'b1;
            else begin
              w_load = 1'b1;
              w_next = S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          mac_clr = 1'b1;
          w_clr   = 1'b1;
          w_next  = S_ISSUE;
        end
        S_ISSUE: begin
          rd_en  = 1'b1;
          w_step = 1'b1;
          if (w_last)
            w_next = S_DRAIN;
        end
        S_DRAIN:   w_next = S_SETTLE;
        S_SETTLE:  w_next = S_CAPTURE;
        S_CAPTURE: w_next = S_HOLD;
        S_HOLD: begin
          if (result_ready) begin
            if (w_more) begin
              w_adv  = 1'b1;
              w_next = S_CLEAR;
            end else begin
              w_done = 1'b1;
              w_next = S_IDLE;
            end
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // rd_en is already low in an abort cycle, so mac_en drops with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_k          <= '0;
      r_num        <= '0;
      r_fc         <= 1'b0;
      mac_en       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      mac_en <= rd_en;
      done   <= w_done;
      err    <= w_err;
      if (w_load) begin
        r_k   <= '0;
        r_num <= num_outputs;
        r_fc  <= (layer == LAYER_FC);
      end else if (w_adv) begin
        r_k <= r_k + 8'd1;
      end
      if (abort && r_state != S_IDLE)
        result_valid <= 1'b0;
      else if (r_state == S_CAPTURE) begin
        result       <= acc_in;
        result_valid <= 1'b1;
      end else if (r_state == S_HOLD && result_ready)
        result_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
